// File: rtl/score_disp_pkg.sv
// Shared types, constants and BCD helper functions for the score display controller.
package score_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  localparam logic [3:0] BLANK_NIB = 4'hF;
  localparam int         MAX_SCORE = 9999;
  localparam int         BCD_W     = 16;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    logic [3:0]       nib;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      nib = bcd[4*i +: 4];
      if (nib >= 4'd5) begin
        res[4*i +: 4] = nib + 4'd3;
      end else begin
        res[4*i +: 4] = nib;
      end
    end
    return res;
  endfunction

  function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd,
                                                     input logic              en);
    logic [BCD_W-1:0] res;
    logic             lead;
    res  = bcd;
    lead = en;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (bcd[4*i +: 4] == 4'd0)) begin
        res[4*i +: 4] = BLANK_NIB;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble engine: one add-3/shift iteration per cycle, BIN_W cycles per value.
module bin2bcd_seq
  import score_disp_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_value,
  output logic             o_done,
  output logic [BCD_W-1:0] o_bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SR_W  = BCD_W + BIN_W;

  logic [SR_W-1:0]  r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic [SR_W-1:0]  w_adj;
  logic [SR_W-1:0]  w_shift;
  logic             w_last;

  assign w_adj   = {dd_adjust(r_sr[SR_W-1 -: BCD_W]), r_sr[BIN_W-1:0]};
  assign w_shift = {w_adj[SR_W-2:0], 1'b0};
  // o_done flags the final iteration so the caller can advance on the same edge.
  assign w_last  = r_run && (r_cnt == CNT_W'(BIN_W - 1));
  assign o_done  = w_last;
  assign o_bcd   = r_sr[SR_W-1 -: BCD_W];

  // Shift register, iteration counter and run flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= {SR_W{1'b0}};
      r_cnt <= {CNT_W{1'b0}};
      r_run <= 1'b0;
    end else if (i_start) begin
      r_sr  <= {{BCD_W{1'b0}}, i_value};
      r_cnt <= {CNT_W{1'b0}};
      r_run <= 1'b1;
    end else if (r_run) begin
      r_sr  <= w_shift;
      r_cnt <= r_cnt + CNT_W'(1);
      r_run <= ~w_last;
    end else begin
      r_sr  <= r_sr;
      r_cnt <= r_cnt;
      r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Score display controller: scan prescaler, update handshake, BCD conversion and atomic digit commit.
// Optional SCAN_SYNC_COMMIT_EN: hold the commit until a scan_en cycle so digits change on scan boundaries.
module score_display_ctrl
  import score_disp_pkg::*;
#(
  parameter int CLK_HZ        = 100000000,
  parameter int SCAN_HZ       = 4000,
  parameter int BIN_W         = 14,
  parameter int BLANK_LEADING = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_valid,
  input  logic [BIN_W-1:0] upd_value,
  output logic             upd_ready,
  output logic             scan_en,
  output logic [3:0]       d3,
  output logic [3:0]       d2,
  output logic [3:0]       d1,
  output logic [3:0]       d0,
  output logic             busy,
  output logic             overflow
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BCD_W-1:0] DIG_RST = (BLANK_LEADING != 0) ?
                                         {BLANK_NIB, BLANK_NIB, BLANK_NIB, 4'h0} : 16'h0000;

  logic [CNT_W-1:0] r_scan_cnt;
  logic             r_scan_en;
  state_t           r_state;
  state_t           w_next_state;
  logic             w_start;
  logic             w_commit;
  logic             w_done;
  logic [BCD_W-1:0] w_bcd;
  logic [31:0]      w_val_ext;
  logic             w_over;
  logic [BIN_W-1:0] w_load;
  logic             r_busy;
  logic             r_overflow;
  logic [BCD_W-1:0] r_digits;

  // Free-running prescaler; the pulse is pre-decoded one count early so scan_en is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= {CNT_W{1'b0}};
      r_scan_en  <= 1'b0;
    end else begin
      if (r_scan_cnt == CNT_W'(DIV - 1)) begin
        r_scan_cnt <= {CNT_W{1'b0}};
      end else begin
        r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end
      r_scan_en <= (r_scan_cnt == CNT_W'(DIV - 2));
    end
  end

  assign w_val_ext = 32'(upd_value);
  assign w_over    = (w_val_ext > 32'(MAX_SCORE));
  assign w_load    = w_over ? BIN_W'(MAX_SCORE) : upd_value;

  bin2bcd_seq #(
    .BIN_W (BIN_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_value (w_load),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // Next-state and strobe decode.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (upd_valid) begin
          w_start      = 1'b1;
          w_next_state = ST_CONVERT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        if (w_done) begin
          w_next_state = ST_COMMIT;
        end else begin
          w_next_state = ST_CONVERT;
        end
      end
      ST_COMMIT: begin
`ifdef SCAN_SYNC_COMMIT_EN
        if (r_scan_en) begin
          w_commit     = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_COMMIT;
        end
`else
        w_commit     = 1'b1;
        w_next_state = ST_IDLE;
`endif
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, status flags and the committed digit bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_digits   <= DIG_RST;
    end else begin
      r_state <= w_next_state;
`ifdef SCAN_SYNC_COMMIT_EN
      r_busy  <= (w_next_state != ST_IDLE);
`else
      r_busy  <= (w_next_state == ST_CONVERT);
`endif
      if (w_start) begin
        r_overflow <= w_over;
      end else begin
        r_overflow <= r_overflow;
      end
      if (w_commit) begin
        r_digits <= blank_leading(w_bcd, (BLANK_LEADING != 0));
      end else begin
        r_digits <= r_digits;
      end
    end
  end

  assign upd_ready = (r_state == ST_IDLE);
  assign scan_en   = r_scan_en;
  assign busy      = r_busy;
  assign overflow  = r_overflow;
  assign d3        = r_digits[15:12];
  assign d2        = r_digits[11:8];
  assign d1        = r_digits[7:4];
  assign d0        = r_digits[3:0];

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench: two controllers (default build, and unblanked with a short scan divider)
// driven with shared stimulus and compared against a decimal-arithmetic reference model.
module tb_score_display_ctrl;

  localparam int DIV_A = 25000;
  localparam int DIV_B = 10;
  localparam int LAT   = 14;

  logic        clk;
  logic        rst_n;
  logic        upd_valid;
  logic [13:0] upd_value;

  logic       ready_a, scan_a, busy_a, ovf_a;
  logic [3:0] d3a, d2a, d1a, d0a;
  logic       ready_b, scan_b, busy_b, ovf_b;
  logic [3:0] d3b, d2b, d1b, d0b;

  logic [15:0] dig_a, dig_b;
  assign dig_a = {d3a, d2a, d1a, d0a};
  assign dig_b = {d3b, d2b, d1b, d0b};

  int          n_chk;
  int          n_fail;
  logic [15:0] exp_a;
  logic [15:0] exp_b;
  logic        exp_ovf;

  score_display_ctrl u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_valid (upd_valid),
    .upd_value (upd_value),
    .upd_ready (ready_a),
    .scan_en   (scan_a),
    .d3        (d3a),
    .d2        (d2a),
    .d1        (d1a),
    .d0        (d0a),
    .busy      (busy_a),
    .overflow  (ovf_a)
  );

  score_display_ctrl #(
    .CLK_HZ        (40),
    .SCAN_HZ       (4),
    .BIN_W         (14),
    .BLANK_LEADING (0)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_valid (upd_valid),
    .upd_value (upd_value),
    .upd_ready (ready_b),
    .scan_en   (scan_b),
    .d3        (d3b),
    .d2        (d2b),
    .d1        (d1b),
    .d0        (d0b),
    .busy      (busy_b),
    .overflow  (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: clamp, split into decimal digits, blank by magnitude.
  function automatic logic [15:0] model_digits(input int v, input bit blank);
    int         c;
    logic [3:0] th, hu, te, on;
    c  = (v > 9999) ? 9999 : v;
    th = 4'(c / 1000);
    hu = 4'((c / 100) % 10);
    te = 4'((c / 10) % 10);
    on = 4'(c % 10);
    if (blank && c < 1000) th = 4'hF;
    if (blank && c < 100)  hu = 4'hF;
    if (blank && c < 10)   te = 4'hF;
    return {th, hu, te, on};
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    upd_valid = 1'b0;
    upd_value = 14'd0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({ready_a, busy_a, ovf_a, scan_a, dig_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'hFFF0}) begin
      n_fail++;
      $display("FAIL reset_a: got rdy=%b busy=%b ovf=%b scan=%b dig=%h, want 1 0 0 0 fff0",
               ready_a, busy_a, ovf_a, scan_a, dig_a);
    end
    n_chk++;
    if ({ready_b, busy_b, ovf_b, scan_b, dig_b} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_b: got rdy=%b busy=%b ovf=%b scan=%b dig=%h, want 1 0 0 0 0000",
               ready_b, busy_b, ovf_b, scan_b, dig_b);
    end
    exp_a   = 16'hFFF0;
    exp_b   = 16'h0000;
    exp_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Must be called right after reset release: edge k after release leaves the counter at k mod DIV.
  task automatic test_scan();
    for (int k = 1; k <= 2 * DIV_A; k++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if ({scan_a, scan_b} !== {((k % DIV_A) == DIV_A - 1), ((k % DIV_B) == DIV_B - 1)}) begin
        n_fail++;
        $display("FAIL scan_pulse: edge %0d got a=%b b=%b", k, scan_a, scan_b);
      end
    end
    n_chk++;
    if (dig_a !== 16'hFFF0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got dig=%h busy=%b, want fff0 0", dig_a, busy_a);
    end
  endtask

  task automatic run_update(input int val);
    logic [15:0] old_a, old_b;
    int          waitc;
    old_a = exp_a;
    old_b = exp_b;
    @(negedge clk);
    upd_value = 14'(val);
    upd_valid = 1'b1;
    waitc = 0;
    while (ready_a !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    n_chk++;
    if (waitc >= 100) begin
      n_fail++;
      $display("FAIL ready_timeout: value %0d never accepted, got ready=%b want 1", val, ready_a);
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      n_chk++;
      if ({busy_a, ready_a, busy_b, dig_a, dig_b} !== {1'b1, 1'b0, 1'b1, old_a, old_b}) begin
        n_fail++;
        $display("FAIL convert_%0d: cyc %0d got busy=%b rdy=%b dig=%h/%h, want 1 0 %h/%h",
                 val, k, busy_a, ready_a, dig_a, dig_b, old_a, old_b);
      end
      @(posedge clk);
      #1;
    end
    n_chk++;
    if ({busy_a, ready_a, dig_a, dig_b} !== {1'b0, 1'b0, old_a, old_b}) begin
      n_fail++;
      $display("FAIL commit_cycle_%0d: got busy=%b rdy=%b dig=%h/%h, want 0 0 %h/%h",
               val, busy_a, ready_a, dig_a, dig_b, old_a, old_b);
    end
    @(posedge clk);
    #1;
    exp_a   = model_digits(val, 1'b1);
    exp_b   = model_digits(val, 1'b0);
    exp_ovf = (val > 9999);
    n_chk++;
    if ({dig_a, dig_b, ovf_a, ovf_b, ready_a, busy_a} !==
        {exp_a, exp_b, exp_ovf, exp_ovf, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL result_%0d: got dig=%h/%h ovf=%b/%b rdy=%b busy=%b, want %h/%h ovf=%b rdy=1 busy=0",
               val, dig_a, dig_b, ovf_a, ovf_b, ready_a, busy_a, exp_a, exp_b, exp_ovf);
    end
  endtask

  task automatic test_basic();
    run_update(1234);
    run_update(7);
    run_update(0);
    run_update(9);
    run_update(10);
    run_update(100);
    run_update(1000);
  endtask

  task automatic test_overflow();
    run_update(12000);
    run_update(42);
    run_update(9999);
    run_update(10000);
    run_update(16383);
    run_update(5);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) begin
        run_update(int'($urandom_range(0, 99)));
      end else begin
        run_update(int'($urandom_range(0, 16383)));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] old_a;
    int          waitc;
    old_a = exp_a;
    @(negedge clk);
    upd_value = 14'd1234;
    upd_valid = 1'b1;
    waitc = 0;
    while (ready_a !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk);
    #1;
    upd_value = 14'd55;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if ({ready_a, dig_a} !== {1'b0, old_a}) begin
        n_fail++;
        $display("FAIL b2b_ignored: edge %0d got rdy=%b dig=%h, want 0 %h", k, ready_a, dig_a, old_a);
      end
    end
    @(posedge clk);
    #1;
    exp_a = model_digits(1234, 1'b1);
    n_chk++;
    if ({ready_a, dig_a} !== {1'b1, exp_a}) begin
      n_fail++;
      $display("FAIL b2b_first: got rdy=%b dig=%h, want 1 %h", ready_a, dig_a, exp_a);
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    n_chk++;
    if ({ready_a, busy_a} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_accept: got rdy=%b busy=%b, want 0 1", ready_a, busy_a);
    end
    repeat (LAT) begin
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (dig_a !== exp_a) begin
      n_fail++;
      $display("FAIL b2b_hold: got dig=%h, want %h", dig_a, exp_a);
    end
    @(posedge clk);
    #1;
    exp_a   = model_digits(55, 1'b1);
    exp_b   = model_digits(55, 1'b0);
    exp_ovf = 1'b0;
    n_chk++;
    if ({dig_a, dig_b} !== {exp_a, exp_b}) begin
      n_fail++;
      $display("FAIL b2b_second: got dig=%h/%h, want %h/%h", dig_a, dig_b, exp_a, exp_b);
    end
  endtask

  task automatic test_reset_mid();
    run_update(12000);
    @(negedge clk);
    upd_value = 14'd9876;
    upd_valid = 1'b1;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({dig_a, dig_b, ovf_a, busy_a, ready_a, scan_a} !==
        {16'hFFF0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got dig=%h/%h ovf=%b busy=%b rdy=%b scan=%b, want fff0/0000 0 0 1 0",
               dig_a, dig_b, ovf_a, busy_a, ready_a, scan_a);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_a   = 16'hFFF0;
    exp_b   = 16'h0000;
    exp_ovf = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    n_chk++;
    if ({dig_a, dig_b, busy_a, ovf_a} !== {exp_a, exp_b, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL no_commit_after_reset: got dig=%h/%h busy=%b ovf=%b, want fff0/0000 0 0",
               dig_a, dig_b, busy_a, ovf_a);
    end
    run_update(321);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_scan();
    test_basic();
    test_overflow();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
